// File: rtl/rule_dispatch_pkg.sv
// Shared types for rule_dispatch: rule ID width, in-flight tag and FSM state.
package rule_dispatch_pkg;

    localparam int RULE_AWIDTH = 8;
    localparam int TAG_LW      = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    typedef struct packed {
        logic              vld;
        logic              last;
        logic [TAG_LW-1:0] lane;
    } tag_t;

endpackage

// File: rtl/rule_dispatch_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr_i wins, one-hot grant.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    always_comb begin
        int   j;
        logic found;
        gnt_o = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rule_dispatch.sv
// Locks one lane per packet, issues its rules to rule_unit and re-tags results.
// Optional statistics counters are built with RULE_DISPATCH_STATS_EN.
module rule_dispatch
    import rule_dispatch_pkg::*;
#(
    parameter  int NUM_LANES  = 4,
    parameter  int RU_LATENCY = 16,
    localparam int LW         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_LANES-1:0]                  lane_valid,
    output logic [NUM_LANES-1:0]                  lane_ready,
    input  logic [NUM_LANES-1:0][RULE_AWIDTH-1:0] lane_rule,
    input  logic [NUM_LANES-1:0]                  lane_last,
    input  logic [NUM_LANES-1:0][15:0]            lane_src_port,
    input  logic [NUM_LANES-1:0][15:0]            lane_dst_port,
    input  logic [NUM_LANES-1:0]                  lane_tcp,
    output logic [RULE_AWIDTH-1:0]                ru_rule_data,
    output logic                                  ru_rule_valid,
    output logic [15:0]                           ru_src_port,
    output logic [15:0]                           ru_dst_port,
    output logic                                  ru_tcp,
    input  logic                                  ru_match,
    input  logic [RULE_AWIDTH-1:0]                ru_match_rule,
    output logic                                  match_valid,
    output logic [RULE_AWIDTH-1:0]                match_rule,
    output logic [LW-1:0]                         match_lane,
    output logic                                  pkt_done,
    output logic [LW-1:0]                         pkt_lane,
    output logic [7:0]                            pkt_match_cnt,
    output logic [31:0]                           stat_pkts,
    output logic [31:0]                           stat_rules,
    output logic [31:0]                           stat_matches
);

    state_e                 state_q;
    logic [LW-1:0]          rr_ptr_q, lock_lane_q;
    logic [NUM_LANES-1:0]   ready_q, gnt;
    logic                   first_q;
    logic [RULE_AWIDTH-1:0] ru_rule_data_q;
    logic                   ru_rule_valid_q, ru_last_q, ru_tcp_q;
    logic [LW-1:0]          ru_lane_q;
    logic [15:0]            ru_src_q, ru_dst_q;
    logic [LW-1:0]          gnt_idx, rr_ptr_d;
    logic                   accept;

    rr_arbiter #(.N(NUM_LANES)) u_arb (
        .req_i (lane_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (gnt[i]) gnt_idx = LW'(i);
    end

    assign rr_ptr_d = (gnt_idx == LW'(NUM_LANES - 1)) ? '0 : gnt_idx + LW'(1);
    assign accept   = |(lane_valid & ready_q);

    // Grant cycle only arms ready; beats flow from the following cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= '0;
            lock_lane_q     <= '0;
            ready_q         <= '0;
            first_q         <= 1'b0;
            ru_rule_valid_q <= 1'b0;
            ru_rule_data_q  <= '0;
            ru_last_q       <= 1'b0;
            ru_lane_q       <= '0;
            ru_src_q        <= '0;
            ru_dst_q        <= '0;
            ru_tcp_q        <= 1'b0;
        end else begin
            ru_rule_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|lane_valid) begin
                        state_q     <= ST_LOCK;
                        lock_lane_q <= gnt_idx;
                        ready_q     <= gnt;
                        rr_ptr_q    <= rr_ptr_d;
                        first_q     <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (accept) begin
                        ru_rule_valid_q <= 1'b1;
                        ru_rule_data_q  <= lane_rule[lock_lane_q];
                        ru_last_q       <= lane_last[lock_lane_q];
                        ru_lane_q       <= lock_lane_q;
                        if (first_q) begin
                            first_q  <= 1'b0;
                            ru_src_q <= lane_src_port[lock_lane_q];
                            ru_dst_q <= lane_dst_port[lock_lane_q];
                            ru_tcp_q <= lane_tcp[lock_lane_q];
                        end
                        if (lane_last[lock_lane_q]) begin
                            state_q <= ST_IDLE;
                            ready_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Tag pipe mirrors rule_unit latency so the exiting tag lines up with ru_match.
    tag_t tag_q [RU_LATENCY];
    tag_t tag_in, tag_exit;

    assign tag_in   = '{vld: ru_rule_valid_q, last: ru_last_q, lane: TAG_LW'(ru_lane_q)};
    assign tag_exit = tag_q[RU_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RU_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i < RU_LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    logic                   hit, done;
    logic [7:0]             cnt_q, cnt_d;
    logic                   match_valid_q, pkt_done_q;
    logic [RULE_AWIDTH-1:0] match_rule_q;
    logic [LW-1:0]          match_lane_q, pkt_lane_q;
    logic [7:0]             pkt_match_cnt_q;

    assign hit   = tag_exit.vld & ru_match;
    assign done  = tag_exit.vld & tag_exit.last;
    assign cnt_d = (hit && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q           <= '0;
            match_valid_q   <= 1'b0;
            match_rule_q    <= '0;
            match_lane_q    <= '0;
            pkt_done_q      <= 1'b0;
            pkt_lane_q      <= '0;
            pkt_match_cnt_q <= '0;
        end else begin
            match_valid_q   <= hit;
            match_rule_q    <= hit ? ru_match_rule : '0;
            match_lane_q    <= hit ? LW'(tag_exit.lane) : '0;
            pkt_done_q      <= done;
            pkt_lane_q      <= done ? LW'(tag_exit.lane) : '0;
            pkt_match_cnt_q <= done ? cnt_d : '0;
            if (tag_exit.vld) cnt_q <= tag_exit.last ? 8'd0 : cnt_d;
        end
    end

`ifdef RULE_DISPATCH_STATS_EN
    logic [31:0] stat_pkts_q, stat_rules_q, stat_matches_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts_q    <= '0;
            stat_rules_q   <= '0;
            stat_matches_q <= '0;
        end else begin
            if (pkt_done_q)      stat_pkts_q    <= stat_pkts_q + 32'd1;
            if (ru_rule_valid_q) stat_rules_q   <= stat_rules_q + 32'd1;
            if (match_valid_q)   stat_matches_q <= stat_matches_q + 32'd1;
        end
    end

    assign stat_pkts    = stat_pkts_q;
    assign stat_rules   = stat_rules_q;
    assign stat_matches = stat_matches_q;
`else
    assign stat_pkts    = '0;
    assign stat_rules   = '0;
    assign stat_matches = '0;
`endif

    assign lane_ready    = ready_q;
    assign ru_rule_data  = ru_rule_data_q;
    assign ru_rule_valid = ru_rule_valid_q;
    assign ru_src_port   = ru_src_q;
    assign ru_dst_port   = ru_dst_q;
    assign ru_tcp        = ru_tcp_q;
    assign match_valid   = match_valid_q;
    assign match_rule    = match_rule_q;
    assign match_lane    = match_lane_q;
    assign pkt_done      = pkt_done_q;
    assign pkt_lane      = pkt_lane_q;
    assign pkt_match_cnt = pkt_match_cnt_q;

endmodule

// File: tb/tb_rule_dispatch.sv
// Directed bench for rule_dispatch with a fixed-latency rule_unit model.
module tb_rule_dispatch;
    import rule_dispatch_pkg::*;

    localparam int NL  = 4;
    localparam int LAT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NL-1:0]                  lane_valid, lane_ready, lane_last, lane_tcp;
    logic [NL-1:0][RULE_AWIDTH-1:0] lane_rule;
    logic [NL-1:0][15:0]            lane_src_port, lane_dst_port;
    logic [RULE_AWIDTH-1:0]         ru_rule_data, ru_match_rule, match_rule;
    logic                           ru_rule_valid, ru_tcp, ru_match, match_valid, pkt_done;
    logic [15:0]                    ru_src_port, ru_dst_port;
    logic [1:0]                     match_lane, pkt_lane;
    logic [7:0]                     pkt_match_cnt;
    logic [31:0]                    stat_pkts, stat_rules, stat_matches;

    rule_dispatch #(.NUM_LANES(NL), .RU_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .lane_valid(lane_valid), .lane_ready(lane_ready), .lane_rule(lane_rule),
        .lane_last(lane_last), .lane_src_port(lane_src_port),
        .lane_dst_port(lane_dst_port), .lane_tcp(lane_tcp),
        .ru_rule_data(ru_rule_data), .ru_rule_valid(ru_rule_valid),
        .ru_src_port(ru_src_port), .ru_dst_port(ru_dst_port), .ru_tcp(ru_tcp),
        .ru_match(ru_match), .ru_match_rule(ru_match_rule),
        .match_valid(match_valid), .match_rule(match_rule), .match_lane(match_lane),
        .pkt_done(pkt_done), .pkt_lane(pkt_lane), .pkt_match_cnt(pkt_match_cnt),
        .stat_pkts(stat_pkts), .stat_rules(stat_rules), .stat_matches(stat_matches)
    );

    // rule_unit model: mode 0 matches rule 9 only, mode 1 matches everything.
    int mmode = 0;
    logic [RULE_AWIDTH:0] mp [LAT];
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) mp[i] <= mp[i-1];
        mp[0] <= {ru_rule_valid, ru_rule_data};
    end
    assign ru_match_rule = mp[LAT-1][RULE_AWIDTH-1:0];
    assign ru_match = mp[LAT-1][RULE_AWIDTH] &&
                      (mmode == 1 || (mmode == 0 && mp[LAT-1][RULE_AWIDTH-1:0] == 8'd9));

    int cyc = 0, n_match = 0, n_done = 0;
    int m_rule, m_lane, m_cyc, d_cnt, d_lane, d_cyc;
    int iss_cyc[$];
    int iss_src[$];
    always @(negedge clk) begin
        cyc++;
        if (ru_rule_valid) begin
            iss_cyc.push_back(cyc);
            iss_src.push_back(int'(ru_src_port));
        end
        if (match_valid) begin
            n_match++; m_rule = int'(match_rule); m_lane = int'(match_lane); m_cyc = cyc;
        end
        if (pkt_done) begin
            n_done++; d_cnt = int'(pkt_match_cnt); d_lane = int'(pkt_lane); d_cyc = cyc;
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int ln, input int rules[$], input logic [15:0] sp);
        for (int b = 0; b < rules.size(); b++) begin
            int g;
            g = 0;
            lane_valid[ln]    = 1'b1;
            lane_rule[ln]     = 8'(rules[b]);
            lane_last[ln]     = (b == rules.size() - 1);
            lane_src_port[ln] = sp;
            lane_dst_port[ln] = 16'hD000 + 16'(ln);
            lane_tcp[ln]      = 1'b1;
            @(negedge clk);
            while (!lane_ready[ln] && g < 500) begin @(negedge clk); g++; end
            if (g >= 500) begin
                chk("send_timeout", g, 0);
                lane_valid[ln] = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        lane_valid[ln] = 1'b0;
        lane_last[ln]  = 1'b0;
    endtask

    // All lanes offer one single-beat packet; records the order they are served.
    task automatic serve_round(output int ord[$]);
        int g;
        g = 0;
        ord = {};
        lane_rule  = {8'd4, 8'd3, 8'd2, 8'd1};
        lane_last  = '1;
        lane_valid = '1;
        while (ord.size() < NL && g < 200) begin
            @(negedge clk); g++;
            for (int l = 0; l < NL; l++)
                if (lane_ready[l] && lane_valid[l]) ord.push_back(l);
            if (ord.size() > 0 && lane_valid[ord[ord.size()-1]] && lane_ready[ord[ord.size()-1]]) begin
                @(posedge clk); #1;
                lane_valid[ord[ord.size()-1]] = 1'b0;
            end
        end
        lane_valid = '0;
        lane_last  = '0;
    endtask

    initial begin
        int ord[$];
        int rl[$];
        int b0, nm0, nd0, g;
        lane_valid = '0; lane_last = '0; lane_tcp = '0;
        lane_rule = '0; lane_src_port = '0; lane_dst_port = '0;

        repeat (20) @(posedge clk);
        #1;
        chk("rst_lane_ready", lane_ready, 0);
        chk("rst_ru_valid", ru_rule_valid, 0);
        chk("rst_match_valid", match_valid, 0);
        chk("rst_pkt_done", pkt_done, 0);
        chk("rst_stat_rules", stat_rules, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Simultaneous requests: served 0,1,2,3 and the next round restarts at 0.
        serve_round(ord);
        chk("rr_cnt", ord.size(), 4);
        for (int i = 0; i < ord.size(); i++) chk("rr_order", ord[i], i);
        serve_round(ord);
        chk("rr_round2_first", (ord.size() > 0) ? ord[0] : -1, 0);
        repeat (25) @(posedge clk); #1;

        // Rules {5,9,3} on lane 0, only 9 matches.
        mmode = 0;
        b0 = iss_cyc.size(); nm0 = n_match; nd0 = n_done;
        rl = '{5, 9, 3};
        send(0, rl, 16'h00AA);
        repeat (25) @(posedge clk); #1;
        chk("p030_issues", iss_cyc.size() - b0, 3);
        if (iss_cyc.size() - b0 == 3) begin
            chk("p030_consec1", iss_cyc[b0+1] - iss_cyc[b0], 1);
            chk("p030_consec2", iss_cyc[b0+2] - iss_cyc[b0+1], 1);
            chk("p030_match_lat", m_cyc - iss_cyc[b0+1], LAT + 1);
            chk("p030_done_lat", d_cyc - iss_cyc[b0+2], LAT + 1);
        end
        chk("p030_matches", n_match - nm0, 1);
        chk("p030_match_rule", m_rule, 9);
        chk("p030_match_lane", m_lane, 0);
        chk("p030_dones", n_done - nd0, 1);
        chk("p030_cnt", d_cnt, 1);
        chk("p030_src", ru_src_port, 16'h00AA);

        // Lane 2, single zero rule.
        b0 = iss_cyc.size(); nm0 = n_match; nd0 = n_done;
        rl = '{0};
        send(2, rl, 16'h0222);
        repeat (25) @(posedge clk); #1;
        chk("p032_issues", iss_cyc.size() - b0, 1);
        chk("p032_matches", n_match - nm0, 0);
        chk("p032_dones", n_done - nd0, 1);
        chk("p032_cnt", d_cnt, 0);
        chk("p032_lane", d_lane, 2);

        // 300-rule packet, all matching: counter saturates at 255.
        mmode = 1;
        nm0 = n_match; nd0 = n_done;
        rl = {};
        for (int i = 0; i < 300; i++) rl.push_back(i % 255 + 1);
        send(1, rl, 16'h0111);
        repeat (25) @(posedge clk); #1;
        chk("p033_matches", n_match - nm0, 300);
        chk("p033_dones", n_done - nd0, 1);
        chk("p033_cnt", d_cnt, 255);
        chk("p033_lane", d_lane, 1);

        // Reset while a 10-rule packet is in flight.
        rl = {};
        for (int i = 1; i <= 10; i++) rl.push_back(i);
        send(3, rl, 16'h0333);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("p034_ru_valid", ru_rule_valid, 0);
        chk("p034_ru_src", ru_src_port, 0);
        chk("p034_match_valid", match_valid, 0);
        chk("p034_pkt_done", pkt_done, 0);
        chk("p034_ready", lane_ready, 0);
        nm0 = n_match; nd0 = n_done;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk); #1;
        chk("p034_no_match", n_match - nm0, 0);
        chk("p034_no_done", n_done - nd0, 0);

        // Bubble mid-packet on lane 1; ports stay latched from beat 1.
        mmode = 0;
        b0 = iss_cyc.size();
        lane_valid[1] = 1'b1; lane_rule[1] = 8'd7; lane_last[1] = 1'b0;
        lane_src_port[1] = 16'h1111; lane_dst_port[1] = 16'hD001; lane_tcp[1] = 1'b1;
        g = 0;
        @(negedge clk);
        while (!lane_ready[1] && g < 100) begin @(negedge clk); g++; end
        chk("p035_grant_wait", g < 100, 1);
        @(posedge clk); #1;
        lane_valid[1] = 1'b0; lane_src_port[1] = 16'h2222;
        lane_dst_port[1] = 16'h2222; lane_tcp[1] = 1'b0;
        @(posedge clk); #1;
        lane_valid[1] = 1'b1; lane_rule[1] = 8'd8; lane_last[1] = 1'b1;
        @(negedge clk);
        chk("p035_ready_kept", lane_ready[1], 1);
        @(posedge clk); #1;
        lane_valid[1] = 1'b0; lane_last[1] = 1'b0;
        repeat (25) @(posedge clk); #1;
        chk("p035_issues", iss_cyc.size() - b0, 2);
        if (iss_cyc.size() - b0 == 2) begin
            chk("p035_gap", iss_cyc[b0+1] - iss_cyc[b0], 2);
            chk("p035_src_b1", iss_src[b0], 16'h1111);
            chk("p035_src_b2", iss_src[b0+1], 16'h1111);
        end
        chk("p035_dst", ru_dst_port, 16'hD001);
        chk("p035_tcp", ru_tcp, 1);
`ifdef RULE_DISPATCH_STATS_EN
        chk("p035_stat_rules", stat_rules, 2);
        chk("p035_stat_pkts", stat_pkts, 1);
        chk("p035_stat_matches", stat_matches, 0);
`else
        chk("p035_stat_rules", stat_rules, 0);
        chk("p035_stat_pkts", stat_pkts, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
